// File: rtl/fu_scalar_lsq.sv
// Queued scalar LSU: DEPTH-entry FIFO, one memory op outstanding, in-order responses; >=2 cycles accept to resp_valid.
// Backpressure: req_ready drops when the FIFO is full or a flush is active; a stalled resp_ready holds the head in RESP.
module fu_scalar_lsq #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_mem_type,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [ADDR_W-1:0]          req_rs1,
    input  logic [ADDR_W-1:0]          req_imm,
    input  logic [31:0]                req_rs2,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       dmemREN,
    output logic                       dmemWEN,
    output logic [ADDR_W-1:0]          dmemaddr,
    output logic [31:0]                dmemstore,
    output logic [3:0]                 dmembyteen,
    input  logic                       dhit_in,
    input  logic [31:0]                dmem_in,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [TAG_W-1:0]           resp_tag,
    output logic [31:0]                resp_data,
    output logic                       resp_is_store,
    output logic                       resp_misalign,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              uns;
        logic [31:0]       data;
        logic [TAG_W-1:0]  tag;
        logic              store;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_en(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    lane_en = 4'b0001 << off;
            2'd1:    lane_en = 4'b0011 << off;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'd0:    lane_rep = {4{d[7:0]}};
            2'd1:    lane_rep = {2{d[15:0]}};
            default: lane_rep = d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size, input logic uns);
        case (size)
            2'd0:    extend = {{24{~uns & w[7]}}, w[7:0]};
            2'd1:    extend = {{16{~uns & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    entry_t             r_mem [DEPTH];
    logic [PTR_W:0]     r_wptr, r_rptr;
    state_t             r_state;
    logic [1:0]         r_iss_off;
    logic [1:0]         r_iss_size;
    logic               r_iss_uns;
    logic [TAG_W-1:0]   r_iss_tag;
    logic               r_iss_store;
    logic               r_ren, r_wen;
    logic [ADDR_W-1:0]  r_daddr;
    logic [31:0]        r_dstore;
    logic [3:0]         r_dbe;
    logic               r_resp_valid;
    logic [TAG_W-1:0]   r_resp_tag;
    logic [31:0]        r_resp_data;
    logic               r_resp_store;
    logic               r_resp_mis;

    logic               w_empty, w_full, w_enq, w_pop, w_head_mis;
    entry_t             w_new, w_head;
    logic [31:0]        w_shift;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign req_ready = !w_full && !flush;
    assign w_enq = req_valid && req_ready && (req_mem_type == 2'd1 || req_mem_type == 2'd2);
    // Flush beats a pop: the queued entries are gone before the FSM may take one.
    assign w_pop = !flush && !w_empty &&
                   ((r_state == S_IDLE) || (r_state == S_RESP && resp_ready));

    assign w_head     = r_mem[r_rptr[PTR_W-1:0]];
    assign w_head_mis = is_misaligned(w_head.addr[1:0], w_head.size);
    assign w_shift    = dmem_in >> {r_iss_off, 3'b000};

    always_comb begin
        w_new       = '0;
        w_new.addr  = req_rs1 + req_imm;
        w_new.size  = req_size;
        w_new.uns   = req_unsigned;
        w_new.data  = req_rs2;
        w_new.tag   = req_tag;
        w_new.store = (req_mem_type == 2'd2);
    end

    always_ff @(posedge CLK) begin
        if (w_enq) r_mem[r_wptr[PTR_W-1:0]] <= w_new;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_state      <= S_IDLE;
            r_iss_off    <= '0;
            r_iss_size   <= '0;
            r_iss_uns    <= 1'b0;
            r_iss_tag    <= '0;
            r_iss_store  <= 1'b0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_daddr      <= '0;
            r_dstore     <= '0;
            r_dbe        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
            r_resp_store <= 1'b0;
            r_resp_mis   <= 1'b0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + PTR_ONE;
            if (flush)      r_rptr <= r_wptr;
            else if (w_pop) r_rptr <= r_rptr + PTR_ONE;

            if (w_pop) begin
                r_iss_off   <= w_head.addr[1:0];
                r_iss_size  <= w_head.size;
                r_iss_uns   <= w_head.uns;
                r_iss_tag   <= w_head.tag;
                r_iss_store <= w_head.store;
                if (w_head_mis) begin
                    // Misaligned ops never touch memory; answer straight from the queue.
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_tag   <= w_head.tag;
                    r_resp_data  <= '0;
                    r_resp_store <= w_head.store;
                    r_resp_mis   <= 1'b1;
                end else begin
                    r_state      <= S_ACCESS;
                    r_resp_valid <= 1'b0;
                    r_ren        <= !w_head.store;
                    r_wen        <= w_head.store;
                    r_daddr      <= {w_head.addr[ADDR_W-1:2], 2'b00};
                    r_dbe        <= lane_en(w_head.addr[1:0], w_head.size);
                    r_dstore     <= w_head.store ? lane_rep(w_head.data, w_head.size) : 32'h0;
                end
            end else begin
                case (r_state)
                    S_ACCESS: if (dhit_in) begin
                        r_state      <= S_RESP;
                        r_ren        <= 1'b0;
                        r_wen        <= 1'b0;
                        r_daddr      <= '0;
                        r_dbe        <= '0;
                        r_dstore     <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_tag   <= r_iss_tag;
                        r_resp_store <= r_iss_store;
                        r_resp_mis   <= 1'b0;
                        r_resp_data  <= r_iss_store ? 32'h0 : extend(w_shift, r_iss_size, r_iss_uns);
                    end
                    S_RESP: if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Strobes fall in the dhit cycle so memory never sees a second request.
    assign dmemREN       = r_ren & ~dhit_in;
    assign dmemWEN       = r_wen & ~dhit_in;
    assign dmemaddr      = r_daddr;
    assign dmemstore     = r_dstore;
    assign dmembyteen    = r_dbe;
    assign resp_valid    = r_resp_valid;
    assign resp_tag      = r_resp_tag;
    assign resp_data     = r_resp_data;
    assign resp_is_store = r_resp_store;
    assign resp_misalign = r_resp_mis;
    assign pending       = r_wptr - r_rptr;

endmodule

// File: tb/tb_fu_scalar_lsq.sv
// Directed bench for fu_scalar_lsq: a memory responder and a response monitor check
// against queues of expected accesses and responses pushed by the stimulus.
module tb_fu_scalar_lsq;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] sdat;
        logic [31:0] rdat;
    } acc_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        st;
        logic        mis;
    } rsp_t;

    logic        CLK, nRST, flush;
    logic        req_valid, req_ready, req_unsigned;
    logic [1:0]  req_mem_type, req_size;
    logic [31:0] req_rs1, req_imm, req_rs2;
    logic [4:0]  req_tag;
    logic        dmemREN, dmemWEN, dhit_in;
    logic [31:0] dmemaddr, dmemstore, dmem_in;
    logic [3:0]  dmembyteen;
    logic        resp_valid, resp_ready, resp_is_store, resp_misalign;
    logic [4:0]  resp_tag;
    logic [31:0] resp_data;
    logic [2:0]  pending;

    fu_scalar_lsq #(.DEPTH(4), .TAG_W(5), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_mem_type(req_mem_type),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_rs1(req_rs1),
        .req_imm(req_imm), .req_rs2(req_rs2), .req_tag(req_tag),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmembyteen(dmembyteen),
        .dhit_in(dhit_in), .dmem_in(dmem_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_data(resp_data), .resp_is_store(resp_is_store),
        .resp_misalign(resp_misalign), .pending(pending)
    );

    int   errors = 0;
    int   checks = 0;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    bit   hold_dhit = 0;
    int   mem_lat = 1;
    int   wait_cnt = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_acc(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] sdat, input logic [31:0] rdat);
        acc_t a;
        a.wr = wr; a.addr = addr; a.be = be; a.sdat = sdat; a.rdat = rdat;
        exp_acc.push_back(a);
    endtask

    task automatic expect_rsp(input logic [4:0] tag, input logic [31:0] data, input logic st, input logic mis);
        rsp_t r;
        r.tag = tag; r.data = data; r.st = st; r.mis = mis;
        exp_rsp.push_back(r);
    endtask

    // Memory model: checks every strobe cycle against the head expectation, answers after mem_lat cycles.
    always @(negedge CLK) begin : responder
        acc_t e;
        #1;
        if (dhit_in) begin
            dhit_in = 1'b0;
        end else if (dmemREN || dmemWEN) begin
            if (exp_acc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: REN=%0b WEN=%0b addr=0x%0h, expected no access",
                         dmemREN, dmemWEN, dmemaddr);
            end else begin
                e = exp_acc[0];
                chk($sformatf("access@%0h", e.addr), {26'h0, dmemWEN, dmemREN, dmembyteen, dmemaddr},
                    {26'h0, e.wr, ~e.wr, e.be, e.addr});
                if (e.wr) chk($sformatf("store_data@%0h", e.addr), {32'h0, dmemstore}, {32'h0, e.sdat});
                if (!hold_dhit && wait_cnt >= mem_lat) begin
                    dhit_in  = 1'b1;
                    dmem_in  = e.rdat;
                    wait_cnt = 0;
                    void'(exp_acc.pop_front());
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge CLK) begin : monitor
        rsp_t r;
        #2;
        if (nRST && resp_valid && resp_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: tag=%0d data=0x%0h, expected no response", resp_tag, resp_data);
            end else begin
                r = exp_rsp.pop_front();
                chk($sformatf("resp_tag%0d", r.tag), {25'h0, resp_tag, resp_data, resp_is_store, resp_misalign},
                    {25'h0, r.tag, r.data, r.st, r.mis});
            end
        end
    end

    task automatic send(input logic [1:0] ty, input logic [1:0] sz, input logic uns,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [4:0] tag);
        int n;
        @(negedge CLK);
        req_valid = 1'b1; req_mem_type = ty; req_size = sz; req_unsigned = uns;
        req_rs1 = rs1; req_imm = imm; req_rs2 = rs2; req_tag = tag;
        #3;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            #3;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag%0d: req_ready=0, expected 1 within 50 cycles", tag);
        end
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, exp_rsp.size());
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int n;
        nRST = 0; flush = 0; req_valid = 0; req_mem_type = 0; req_size = 0; req_unsigned = 0;
        req_rs1 = 0; req_imm = 0; req_rs2 = 0; req_tag = 0; dhit_in = 0; dmem_in = 0; resp_ready = 1;
        repeat (3) @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        #3;
        chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
        chk("reset_outputs", {56'h0, resp_valid, dmemREN, dmemWEN, dmembyteen, resp_misalign},
            64'h0);
        chk("reset_pending", {61'h0, pending}, 64'h0);
        chk("reset_dmemaddr", {32'h0, dmemaddr}, 64'h0);

        // Word load, dhit one cycle after the strobe.
        mem_lat = 1;
        expect_acc(0, 32'h104, 4'b1111, 0, 32'hDEADBEEF);
        expect_rsp(5'd3, 32'hDEADBEEF, 0, 0);
        send(2'd1, 2'd2, 0, 32'h100, 32'h4, 0, 5'd3);
        wait_done(20, "load_word");

        // Sub-word loads; first one also checks minimum latency with a same-cycle dhit.
        mem_lat = 0;
        expect_acc(0, 32'h200, 4'b1000, 0, 32'h80123456);
        expect_rsp(5'd4, 32'hFFFFFF80, 0, 0);
        send(2'd1, 2'd0, 0, 32'h200, 32'h3, 0, 5'd4);
        #3;
        chk("lat_e0_no_resp", {63'h0, resp_valid}, 64'h0);
        @(negedge CLK);
        #3;
        chk("strobe_drops_on_dhit", {62'h0, dmemREN, resp_valid}, 64'h0);
        chk("addr_held_on_dhit", {32'h0, dmemaddr}, 64'h200);
        @(negedge CLK);
        #3;
        chk("lat_e2_resp_valid", {63'h0, resp_valid}, 64'h1);
        wait_done(20, "byte_signed");
        expect_acc(0, 32'h200, 4'b1000, 0, 32'h80123456);
        expect_rsp(5'd5, 32'h00000080, 0, 0);
        send(2'd1, 2'd0, 1, 32'h200, 32'h3, 0, 5'd5);
        expect_acc(0, 32'h200, 4'b1100, 0, 32'h80011234);
        expect_rsp(5'd6, 32'hFFFF8001, 0, 0);
        send(2'd1, 2'd1, 0, 32'h200, 32'h2, 0, 5'd6);
        wait_done(30, "subword_loads");

        // Stores of each size.
        mem_lat = 1;
        expect_acc(1, 32'h300, 4'b0010, 32'h78787878, 0);
        expect_rsp(5'd7, 0, 1, 0);
        send(2'd2, 2'd0, 0, 32'h300, 32'h1, 32'h12345678, 5'd7);
        expect_acc(1, 32'h300, 4'b1100, 32'hCCDDCCDD, 0);
        expect_rsp(5'd8, 0, 1, 0);
        send(2'd2, 2'd1, 0, 32'h300, 32'h2, 32'hAABBCCDD, 5'd8);
        expect_acc(1, 32'h308, 4'b1111, 32'hCAFEF00D, 0);
        expect_rsp(5'd9, 0, 1, 0);
        send(2'd2, 2'd2, 0, 32'h300, 32'h8, 32'hCAFEF00D, 5'd9);
        wait_done(40, "stores");

        // Misaligned ops respond without memory access; order preserved; address wraps.
        expect_rsp(5'd10, 0, 0, 1);
        send(2'd1, 2'd2, 0, 32'h100, 32'h2, 0, 5'd10);
        expect_acc(0, 32'h108, 4'b1111, 0, 32'h11223344);
        expect_rsp(5'd11, 32'h11223344, 0, 0);
        send(2'd1, 2'd2, 0, 32'h100, 32'h8, 0, 5'd11);
        expect_rsp(5'd12, 0, 1, 1);
        send(2'd2, 2'd1, 0, 32'h300, 32'h1, 32'hFFFF, 5'd12);
        expect_acc(0, 32'h8, 4'b1111, 0, 32'h0BADF00D);
        expect_rsp(5'd13, 32'h0BADF00D, 0, 0);
        send(2'd1, 2'd2, 0, 32'h10, 32'hFFFFFFF8, 0, 5'd13);
        wait_done(40, "misalign_order");

        // NONE is accepted and dropped.
        send(2'd0, 2'd2, 0, 32'h500, 0, 0, 5'd14);
        #3;
        chk("none_dropped_pending", {61'h0, pending}, 64'h0);
        repeat (4) @(negedge CLK);

        // Fill and backpressure.
        hold_dhit = 1;
        mem_lat = 0;
        for (int i = 0; i < 5; i++) begin
            expect_acc(0, 32'h400 + 32'(4 * i), 4'b1111, 0, 32'hA0000000 + 32'(i));
            expect_rsp(5'(16 + i), 32'hA0000000 + 32'(i), 0, 0);
            send(2'd1, (i == 4) ? 2'd3 : 2'd2, 0, 32'h400, 32'(4 * i), 0, 5'(16 + i));
        end
        @(negedge CLK);
        req_valid = 1; req_mem_type = 2'd1; req_size = 2'd2; req_rs1 = 32'h500; req_imm = 0; req_tag = 5'd31;
        #3;
        chk("full_req_ready", {63'h0, req_ready}, 64'h0);
        chk("full_pending", {61'h0, pending}, 64'h4);
        @(negedge CLK);
        #3;
        chk("full_req_ready_held", {63'h0, req_ready}, 64'h0);
        @(negedge CLK);
        req_valid = 0;
        resp_ready = 0;
        hold_dhit = 0;
        n = 0;
        do begin
            @(negedge CLK);
            #3;
            n++;
        end while (!resp_valid && n < 10);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_hold%0d", k), {31'h0, resp_valid, resp_data}, {31'h0, 1'b1, 32'hA0000000});
            @(negedge CLK);
            #3;
        end
        chk("stall_tag", {59'h0, resp_tag}, 64'd16);
        @(negedge CLK);
        resp_ready = 1;
        wait_done(12, "fill_drain");

        // Flush while one op is in ACCESS and three are queued.
        hold_dhit = 1;
        mem_lat = 1;
        expect_acc(0, 32'h600, 4'b1111, 0, 32'h5555AAAA);
        expect_rsp(5'd21, 32'h5555AAAA, 0, 0);
        send(2'd1, 2'd2, 0, 32'h600, 0, 0, 5'd21);
        for (int i = 1; i < 4; i++) send(2'd1, 2'd2, 0, 32'h600, 32'(4 * i), 0, 5'(21 + i));
        #3;
        chk("preflush_pending", {61'h0, pending}, 64'h3);
        @(negedge CLK);
        flush = 1;
        #3;
        chk("flush_blocks_req", {63'h0, req_ready}, 64'h0);
        @(negedge CLK);
        flush = 0;
        #3;
        chk("flush_pending", {61'h0, pending}, 64'h0);
        @(negedge CLK);
        hold_dhit = 0;
        wait_done(20, "flush_inflight");
        repeat (6) @(negedge CLK);
        #3;
        chk("post_flush_idle", {60'h0, pending, resp_valid}, 64'h0);

        // Reset in the middle of an access.
        hold_dhit = 1;
        expect_acc(0, 32'h700, 4'b1111, 0, 0);
        send(2'd1, 2'd2, 0, 32'h700, 0, 0, 5'd25);
        n = 0;
        do begin
            @(negedge CLK);
            #3;
            n++;
        end while (!dmemREN && n < 10);
        chk("strobe_before_reset", {63'h0, dmemREN}, 64'h1);
        @(negedge CLK);
        nRST = 0;
        #3;
        chk("reset_drops_strobe", {62'h0, dmemREN, resp_valid}, 64'h0);
        chk("reset_req_ready_mid", {63'h0, req_ready}, 64'h1);
        exp_acc.delete();
        wait_cnt = 0;
        hold_dhit = 0;
        repeat (2) @(negedge CLK);
        nRST = 1;
        repeat (5) @(negedge CLK);
        #3;
        chk("no_resp_after_reset", {60'h0, resp_valid, pending}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_scalar_lsq.md
Name: fu_scalar_lsq

Overview:
Queued scalar load/store functional unit for the scalar pipe, replacing the single-entry latch-based LS unit.
- Accepts tagged LOAD/STORE requests through a valid/ready handshake into a DEPTH-entry FIFO.
- Issues them one at a time to the data-memory port with byte enables, and returns sign- or zero-extended load data or store completion through a valid/ready response port.
- Adds sub-word access, misalignment detection, flush and back-to-back issue.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
TAG_W, 5, width of the request tag returned with the response
ADDR_W, 32, address width (data width fixed at 32, 4 byte lanes)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
flush  in  1  drop all queued, not-yet-issued requests
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_mem_type  in  2  0 NONE, 1 LOAD, 2 STORE
req_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
req_unsigned  in  1  zero-extend load when 1
req_rs1  in  ADDR_W  base address
req_imm  in  ADDR_W  offset
req_rs2  in  32  store data (low bits used for sub-word)
req_tag  in  TAG_W  request tag
dmemREN  out  1  memory read strobe
dmemWEN  out  1  memory write strobe
dmemaddr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmemstore  out  32  lane-replicated store data
dmembyteen  out  4  byte enables
dhit_in  in  1  memory completion
dmem_in  in  32  memory read word
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_tag  out  TAG_W  tag of completed request
resp_data  out  32  extended load data; 0 for stores and errors
resp_is_store  out  1  completed op was a store
resp_misalign  out  1  misaligned access, no memory op performed
pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, state IDLE, all outputs 0 except req_ready=1.
- Reset asserted mid-access drops strobes immediately and discards the in-flight op; no response is produced.
- Enqueue: on req_valid & req_ready & mem_type in {LOAD, STORE}.
  - Store addr = rs1+imm (mod 2^ADDR_W), size, unsigned, rs2, tag and type.
  - mem_type NONE is accepted and discarded.
- req_ready = !full & !flush. No same-cycle enqueue into a full FIFO even when it dequeues.
- FIFO: circular, pointers wrap at DEPTH, extra MSB distinguishes full/empty.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- State machine:
  - IDLE: if FIFO non-empty, pop head into issue register at the next edge. Go to RESP if misaligned, else to ACCESS.
  - ACCESS:
    - dmemaddr = {addr[ADDR_W-1:2], 2'b00}.
    - LOAD asserts dmemREN. STORE asserts dmemWEN, with dmemstore = byte replicated x4 / half replicated x2 / word.
    - dmembyteen: byte = 1<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. Loads drive the same enables.
    - While waiting for dhit_in, strobes, address, data and byte enables are held stable.
    - When dhit_in is high: strobes drop combinationally in that cycle and load data is captured.
    - Loaded word is shifted right by addr[1:0]*8, then sign/zero extended per size and unsigned.
    - Next state is RESP.
  - RESP: resp_valid=1 with registered resp_* fields held stable.
    - On resp_ready: if FIFO non-empty, pop the next head and go directly to ACCESS, or to RESP if it is misaligned. Otherwise go to IDLE.
    - Misaligned responses: resp_misalign=1, resp_data=0, dmem strobes never asserted.
- Latency: request accepted at edge E0 → strobe after E1 → with a same-cycle dhit, resp_valid after E2. Minimum 2 cycles.
- flush: synchronous, empties FIFO (pending=0 next cycle). The issue register and any ACCESS/RESP in progress complete normally. A flush while in IDLE with a non-empty FIFO wins over the pop.
- Simultaneous enqueue and pop: occupancy unchanged, entry order preserved.
- Responses return in request order.

Test Plan:
1. Load word: rs1=0x100, imm=0x4, tag=3, dmem_in=0xDEADBEEF, dhit one cycle after the strobe → dmemaddr=0x104, byteen=1111, resp_data=0xDEADBEEF, tag=3, misalign=0.
2. Signed/unsigned byte: addr=0x203, dmem_in=0x80xxxxxx → byteen=1000; signed gives 0xFFFFFF80, unsigned gives 0x00000080. Half at 0x202 with dmem_in=0x8001xxxx → 0xFFFF8001.
3. Store byte: addr=0x301, rs2=0x12345678 → dmemWEN=1, byteen=0010, dmemstore=0x78787878, resp_is_store=1, resp_data=0.
4. Misaligned word load at 0x102, then aligned load → first response has misalign=1 with no dmemREN; second issues normally; tags stay in order.
5. Fill and backpressure: DEPTH=4, hold dhit_in=0 and issue 6 requests.
   - Expected: 1 request enters ACCESS and 4 are queued; req_ready falls and pending=4.
   - Hold resp_ready=0 for 3 cycles: resp_valid stays high with stable data.
   - Release: all 5 complete back-to-back in order.
6. Flush with 3 queued while one is in ACCESS → in-flight op completes with 1 response, pending=0, and no further strobes. Assert nRST during ACCESS → dmemREN drops immediately and resp_valid=0.
